// File: rtl/uarch_clr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uarch_clr_sequencer_pkg
// Brief    : State encoding, default constants and helpers for the clear sequencer.
// Revision : 1.0
// ============================================================================
package uarch_clr_sequencer_pkg;

    typedef enum logic [2:0] {
        UARCH_CLR_IDLE      = 3'd0,
        UARCH_CLR_ASSERT    = 3'd1,
        UARCH_CLR_WAIT_INIT = 3'd2,
        UARCH_CLR_NEXT      = 3'd3,
        UARCH_CLR_DONE      = 3'd4
    } uarch_clr_state_e;

    localparam int UARCH_CLR_HOLD    = 16;
    localparam int UARCH_CLR_TIMEOUT = 1024;

    // Index width with a floor of one bit so a single-domain build still has a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uarch_clr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : uarch_clr_sequencer_if
// Brief    : Start/clear/acknowledge bundle between flush control, sequencer and units.
// Revision : 1.0
// ============================================================================
interface uarch_clr_sequencer_if
    import uarch_clr_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS = 4
);
    localparam int c_IDX_W = idx_width(NUM_DOMAINS);

    logic                   start_i;
    logic [NUM_DOMAINS-1:0] domain_mask_i;
    logic [NUM_DOMAINS-1:0] init_done_i;
    logic [NUM_DOMAINS-1:0] clr_o;
    logic [c_IDX_W-1:0]     cur_domain_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   timeout_o;

    modport master (
        output start_i, domain_mask_i, init_done_i,
        input  clr_o, cur_domain_o, busy_o, done_o, timeout_o
    );

    modport slave (
        input  start_i, domain_mask_i, init_done_i,
        output clr_o, cur_domain_o, busy_o, done_o, timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/uarch_clr_sequencer_lzc.sv
`default_nettype none
// ============================================================================
// Module   : uarch_clr_sequencer_lzc
// Brief    : Trailing-zero count: index of the lowest set bit, empty when all zero.
// Revision : 1.0
// ============================================================================
module uarch_clr_sequencer_lzc #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  wire logic [WIDTH-1:0] in_i,
    output logic      [CNT_W-1:0] cnt_o,
    output logic                  empty_o
);
    always_comb begin
        cnt_o   = '0;
        empty_o = 1'b1;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                cnt_o   = CNT_W'(i);
                empty_o = 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/uarch_clr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : uarch_clr_sequencer
// Brief    : Post-fence microarchitectural clear, one domain at a time, with
//            hold, init-done wait and timeout. UARCH_CLR_PARALLEL_EN clears
//            all masked domains together instead.
// Revision : 1.0
// ============================================================================
module uarch_clr_sequencer
    import uarch_clr_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS  = 4,
    parameter int HOLD_CYCLES  = UARCH_CLR_HOLD,
    parameter int INIT_TIMEOUT = UARCH_CLR_TIMEOUT
) (
    input wire logic             clk_i,
    input wire logic             rst_ni,
    uarch_clr_sequencer_if.slave bus
);
    localparam int c_IDX_W  = idx_width(NUM_DOMAINS);
    localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int c_TO_W   = $clog2(INIT_TIMEOUT + 1);

    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(INIT_TIMEOUT - 1);

    localparam logic [2:0] c_ST_IDLE      = UARCH_CLR_IDLE;
    localparam logic [2:0] c_ST_ASSERT    = UARCH_CLR_ASSERT;
    localparam logic [2:0] c_ST_WAIT_INIT = UARCH_CLR_WAIT_INIT;
    localparam logic [2:0] c_ST_NEXT      = UARCH_CLR_NEXT;
    localparam logic [2:0] c_ST_DONE      = UARCH_CLR_DONE;

    logic [2:0]             r_state;
    logic [NUM_DOMAINS-1:0] r_mask;
    logic [c_IDX_W-1:0]     r_cur;
    logic [c_HOLD_W-1:0]    r_hold;
    logic [c_TO_W-1:0]      r_tmo;
    logic                   r_timeout;
    logic                   w_init_ok;

`ifdef UARCH_CLR_PARALLEL_EN
    localparam logic [2:0] c_ST_AFTER_WAIT = c_ST_DONE;

    assign w_init_ok = ((bus.init_done_i & r_mask) == r_mask);
`else
    localparam logic [2:0] c_ST_AFTER_WAIT = c_ST_NEXT;

    logic [NUM_DOMAINS-1:0] w_cur_oh;
    logic [NUM_DOMAINS-1:0] w_mask_rem;
    logic [NUM_DOMAINS-1:0] w_lzc_in;
    logic [c_IDX_W-1:0]     w_lzc_cnt;
    logic                   w_lzc_empty;

    assign w_cur_oh   = NUM_DOMAINS'(1) << r_cur;
    assign w_mask_rem = r_mask & ~w_cur_oh;
    // In IDLE the mask is not latched yet, so search the incoming one directly.
    assign w_lzc_in   = (r_state == c_ST_IDLE) ? bus.domain_mask_i : w_mask_rem;
    assign w_init_ok  = bus.init_done_i[r_cur];

    uarch_clr_sequencer_lzc #(
        .WIDTH (NUM_DOMAINS),
        .CNT_W (c_IDX_W)
    ) u_lzc (
        .in_i    (w_lzc_in),
        .cnt_o   (w_lzc_cnt),
        .empty_o (w_lzc_empty)
    );
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= c_ST_IDLE;
            r_mask    <= '0;
            r_cur     <= '0;
            r_hold    <= '0;
            r_tmo     <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start_i) begin
                        r_mask    <= bus.domain_mask_i;
                        r_timeout <= 1'b0;
                        r_hold    <= '0;
                        r_tmo     <= '0;
`ifdef UARCH_CLR_PARALLEL_EN
                        r_state   <= (|bus.domain_mask_i) ? c_ST_ASSERT : c_ST_DONE;
`else
                        if (!w_lzc_empty) begin
                            r_cur   <= w_lzc_cnt;
                            r_state <= c_ST_ASSERT;
                        end else begin
                            r_state <= c_ST_DONE;
                        end
`endif
                    end
                end
                c_ST_ASSERT: begin
                    if (r_hold == c_HOLD_LAST) begin
                        r_hold  <= '0;
                        r_state <= c_ST_WAIT_INIT;
                    end else begin
                        r_hold  <= r_hold + 1'b1;
                    end
                end
                c_ST_WAIT_INIT: begin
                    if (w_init_ok) begin
                        r_tmo   <= '0;
                        r_state <= c_ST_AFTER_WAIT;
                    end else if (r_tmo == c_TO_LAST) begin
                        r_tmo     <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= c_ST_AFTER_WAIT;
                    end else begin
                        r_tmo   <= r_tmo + 1'b1;
                    end
                end
`ifndef UARCH_CLR_PARALLEL_EN
                c_ST_NEXT: begin
                    r_mask <= w_mask_rem;
                    if (!w_lzc_empty) begin
                        r_cur   <= w_lzc_cnt;
                        r_state <= c_ST_ASSERT;
                    end else begin
                        r_state <= c_ST_DONE;
                    end
                end
`endif
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset drops them at once.
    always_comb begin
        bus.clr_o = '0;
        if (r_state == c_ST_ASSERT) begin
`ifdef UARCH_CLR_PARALLEL_EN
            bus.clr_o = r_mask;
`else
            bus.clr_o = w_cur_oh;
`endif
        end
    end

    assign bus.cur_domain_o = r_cur;
    assign bus.busy_o       = (r_state != c_ST_IDLE);
    assign bus.done_o       = (r_state == c_ST_DONE);
    assign bus.timeout_o    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uarch_clr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uarch_clr_sequencer
// Brief    : Directed plus random transactions against a schedule-level model.
// Revision : 1.0
// ============================================================================
module tb_uarch_clr_sequencer;
    localparam int ND   = 4;
    localparam int HOLD = 16;
    localparam int TO   = 8;
    localparam int IW   = 2;
    localparam int MAXC = 128;

    logic clk;
    logic rst_ni;
    int   total;
    int   bad;
    int   dly [ND];
    logic [IW-1:0] last_cur;

    logic [ND-1:0] e_clr [MAXC];
    logic [ND-1:0] e_drv [MAXC];
    logic [IW-1:0] e_cur [MAXC];

    uarch_clr_sequencer_if #(.NUM_DOMAINS(ND)) bus ();

    uarch_clr_sequencer #(
        .NUM_DOMAINS  (ND),
        .HOLD_CYCLES  (HOLD),
        .INIT_TIMEOUT (TO)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Builds the expected cycle schedule from the domain order, hold length and
    // per-domain ack delays, then runs it. Cycle 0 is the start cycle.
    task automatic run_txn(input logic [ND-1:0] mask, input int abort_k);
        int t, w, fin, done_k, tt, last, maxd;
        t = 0; tt = 0; last = int'(last_cur); done_k = 1; w = 0; fin = 0; maxd = 0;
        for (int k = 0; k < MAXC; k++) begin
            e_clr[k] = '0;
            e_cur[k] = last_cur;
            e_drv[k] = ND'($urandom);
        end
`ifndef UARCH_CLR_PARALLEL_EN
        for (int d = 0; d < ND; d++) begin
            if (mask[d]) begin
                for (int k = t + 1; k <= t + HOLD; k++) e_clr[k] = ND'(1) << d;
                w = t + HOLD + 1;
                if (dly[d] <= TO - 1) fin = w + dly[d];
                else begin
                    fin = w + TO - 1;
                    if (tt == 0) tt = fin + 1;
                end
                for (int k = w; k <= fin; k++) e_drv[k][d] = (k >= w + dly[d]);
                for (int k = t + 1; k <= fin + 1; k++) e_cur[k] = IW'(d);
                t = fin + 1;
                last = d;
            end
        end
        done_k = t + 1;
`else
        if (mask != '0) begin
            for (int k = 1; k <= HOLD; k++) e_clr[k] = mask;
            w = HOLD + 1;
            for (int d = 0; d < ND; d++) if (mask[d] && dly[d] > maxd) maxd = dly[d];
            if (maxd <= TO - 1) fin = w + maxd;
            else begin
                fin = w + TO - 1;
                tt  = fin + 1;
            end
            for (int d = 0; d < ND; d++)
                if (mask[d])
                    for (int k = w; k <= fin; k++) e_drv[k][d] = (k >= w + dly[d]);
            done_k = fin + 1;
        end else begin
            done_k = 1;
        end
        last = 0;
        t = done_k - 1;
`endif
        for (int k = t + 1; k <= done_k + 1; k++) e_cur[k] = IW'(last);

        bus.start_i       = 1'b1;
        bus.domain_mask_i = mask;
        bus.init_done_i   = e_drv[0];
        for (int k = 1; k <= done_k + 1; k++) begin
            @(posedge clk); #1;
            check($sformatf("clr m=%b c=%0d", mask, k), 32'(bus.clr_o), 32'(e_clr[k]));
            check($sformatf("busy m=%b c=%0d", mask, k), 32'(bus.busy_o), 32'(k <= done_k));
            check($sformatf("done m=%b c=%0d", mask, k), 32'(bus.done_o), 32'(k == done_k));
            check($sformatf("timeout m=%b c=%0d", mask, k), 32'(bus.timeout_o),
                  32'(tt != 0 && k >= tt));
            check($sformatf("cur m=%b c=%0d", mask, k), 32'(bus.cur_domain_o), 32'(e_cur[k]));
            if (k == abort_k) begin
                #2 rst_ni = 1'b0;
                #1;
                check("rst clr", 32'(bus.clr_o), 32'd0);
                check("rst busy", 32'(bus.busy_o), 32'd0);
                check("rst done", 32'(bus.done_o), 32'd0);
                check("rst timeout", 32'(bus.timeout_o), 32'd0);
                check("rst cur", 32'(bus.cur_domain_o), 32'd0);
                bus.start_i = 1'b0;
                last_cur    = '0;
                @(negedge clk);
                rst_ni = 1'b1;
                return;
            end
            bus.init_done_i = e_drv[k];
            // Starts while busy (including the done cycle) must be ignored.
            if (k <= done_k) begin
                bus.start_i       = 1'($urandom);
                bus.domain_mask_i = ND'($urandom);
            end else begin
                bus.start_i = 1'b0;
            end
        end
        last_cur = IW'(last);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        last_cur          = '0;
        rst_ni            = 1'b0;
        bus.start_i       = 1'b0;
        bus.domain_mask_i = '0;
        bus.init_done_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset clr", 32'(bus.clr_o), 32'd0);
        check("reset busy", 32'(bus.busy_o), 32'd0);
        check("reset done", 32'(bus.done_o), 32'd0);
        check("reset timeout", 32'(bus.timeout_o), 32'd0);
        check("reset cur", 32'(bus.cur_domain_o), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        dly = '{0, 0, 0, 0};
        run_txn(4'b0100, 0);
        dly = '{3, 3, 3, 3};
        run_txn(4'b1011, 0);
        dly = '{TO + 1, TO + 1, TO + 1, TO + 1};
        run_txn(4'b0001, 0);
        run_txn(4'b0000, 0);
        dly = '{1, 2, 0, 3};
        run_txn(4'b0110, 5);
        run_txn(4'b0110, 0);
        dly = '{0, 2, 5, 0};
        run_txn(4'b0110, 0);
        dly = '{0, TO - 1, 0, 0};
        run_txn(4'b0010, 0);

        for (int n = 0; n < 24; n++) begin
            for (int d = 0; d < ND; d++) dly[d] = int'($urandom_range(0, TO + 1));
            run_txn(ND'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
